// File: rtl/odd_result_fwd.sv
// Permute-unit result forwarding: a 3-deep result shift line that feeds the
// register-file write port and supplies newest-first operand bypass.
module odd_result_fwd (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] in_rt,
  input  logic [6:0]   in_rt_addr,
  input  logic         in_reg_write,
  input  logic         flush,
  input  logic [6:0]   ra_addr,
  input  logic [6:0]   rb_addr,
  input  logic [6:0]   rc_addr,
  output logic [0:127] ra_fwd,
  output logic [0:127] rb_fwd,
  output logic [0:127] rc_fwd,
  output logic         ra_hit,
  output logic         rb_hit,
  output logic         rc_hit,
  output logic         rf_we,
  output logic [6:0]   rf_waddr,
  output logic [0:127] rf_wdata,
  output logic [15:0]  retire_count
);

  logic [2:0][127:0] fw_data_r;
  logic [2:0][6:0]   fw_addr_r;
  logic [2:0]        fw_we_r;
  logic [15:0]       retire_count_r;

  logic              cap_we_s;
  logic [3:0][127:0] src_data_s;
  logic [3:0][6:0]   src_addr_s;
  logic [3:0]        src_we_s;
  logic [128:0]      ra_res_s;
  logic [128:0]      rb_res_s;
  logic [128:0]      rc_res_s;

  // Oldest source is scanned first so a newer match overwrites it: index 0 wins.
  function automatic logic [128:0] fwd_lookup(
    input logic [6:0]        addr,
    input logic [3:0]        we,
    input logic [3:0][6:0]   addrs,
    input logic [3:0][127:0] data
  );
    logic [128:0] res;
    res = {1'b0, 128'd0};
    for (int i = 3; i >= 0; i--) begin
      res = (we[i] && (addrs[i] == addr)) ? {1'b1, data[i]} : res;
    end
    return res;
  endfunction

  assign cap_we_s = in_reg_write & ~flush;

  // Result shift line and retirement counter; reset clears all in-flight results.
  always_ff @(posedge clk) begin
    if (reset) begin
      fw_data_r      <= '0;
      fw_addr_r      <= '0;
      fw_we_r        <= 3'b000;
      retire_count_r <= 16'd0;
    end else begin
      fw_data_r[2]   <= fw_data_r[1];
      fw_addr_r[2]   <= fw_addr_r[1];
      fw_we_r[2]     <= fw_we_r[1];
      fw_data_r[1]   <= fw_data_r[0];
      fw_addr_r[1]   <= fw_addr_r[0];
      fw_we_r[1]     <= fw_we_r[0];
      fw_data_r[0]   <= cap_we_s ? in_rt : 128'd0;
      fw_addr_r[0]   <= cap_we_s ? in_rt_addr : 7'd0;
      fw_we_r[0]     <= cap_we_s;
      retire_count_r <= retire_count_r + {15'd0, fw_we_r[2]};
    end
  end

  // Bypass sources ordered newest first; index 0 is the live input.
  always_comb begin
    src_data_s    = '0;
    src_addr_s    = '0;
    src_we_s      = 4'b0000;
    src_data_s[0] = in_rt;
    src_addr_s[0] = in_rt_addr;
    src_we_s[0]   = cap_we_s;
    for (int i = 0; i < 3; i++) begin
      src_data_s[i+1] = fw_data_r[i];
      src_addr_s[i+1] = fw_addr_r[i];
      src_we_s[i+1]   = fw_we_r[i];
    end
    ra_res_s = fwd_lookup(ra_addr, src_we_s, src_addr_s, src_data_s);
    rb_res_s = fwd_lookup(rb_addr, src_we_s, src_addr_s, src_data_s);
    rc_res_s = fwd_lookup(rc_addr, src_we_s, src_addr_s, src_data_s);
  end

  assign ra_hit       = ra_res_s[128];
  assign ra_fwd       = ra_res_s[127:0];
  assign rb_hit       = rb_res_s[128];
  assign rb_fwd       = rb_res_s[127:0];
  assign rc_hit       = rc_res_s[128];
  assign rc_fwd       = rc_res_s[127:0];

  assign rf_we        = fw_we_r[2];
  assign rf_waddr     = fw_addr_r[2];
  assign rf_wdata     = fw_data_r[2];
  assign retire_count = retire_count_r;

endmodule

// File: tb/tb_odd_result_fwd.sv
// Randomized and directed bench for odd_result_fwd against a history-based
// reference model of accepted results.
module tb_odd_result_fwd;

  logic         clk;
  logic         reset;
  logic [0:127] in_rt;
  logic [6:0]   in_rt_addr;
  logic         in_reg_write;
  logic         flush;
  logic [6:0]   ra_addr, rb_addr, rc_addr;
  logic [0:127] ra_fwd, rb_fwd, rc_fwd;
  logic         ra_hit, rb_hit, rc_hit;
  logic         rf_we;
  logic [6:0]   rf_waddr;
  logic [0:127] rf_wdata;
  logic [15:0]  retire_count;

  odd_result_fwd dut (
    .clk(clk), .reset(reset), .in_rt(in_rt), .in_rt_addr(in_rt_addr),
    .in_reg_write(in_reg_write), .flush(flush),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_fwd(ra_fwd), .rb_fwd(rb_fwd), .rc_fwd(rc_fwd),
    .ra_hit(ra_hit), .rb_hit(rb_hit), .rc_hit(rc_hit),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         we;
    logic [6:0]   addr;
    logic [127:0] data;
  } ent_t;

  // Reference: hist[k] is the result accepted k+1 cycles ago (newest at front).
  ent_t        hist[$];
  logic [15:0] m_count;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [128:0] model_fwd(input logic [6:0] a, input ent_t live);
    if (live.we && live.addr == a) return {1'b1, live.data};
    foreach (hist[k]) if (hist[k].we && hist[k].addr == a) return {1'b1, hist[k].data};
    return 129'd0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    ent_t z;
    z = '0;
    hist.delete();
    repeat (3) hist.push_back(z);
    m_count = 16'd0;
  endtask

  task automatic step(input logic r, input logic w, input logic f, input logic [6:0] a,
                      input logic [127:0] d, input logic [6:0] pa, input logic [6:0] pb,
                      input logic [6:0] pc);
    ent_t         live;
    logic [128:0] ea, eb, ec;
    @(negedge clk);
    reset = r; in_reg_write = w; flush = f; in_rt_addr = a; in_rt = d;
    ra_addr = pa; rb_addr = pb; rc_addr = pc;
    #1;
    live.we   = w & ~f;
    live.addr = live.we ? a : 7'd0;
    live.data = live.we ? d : 128'd0;
    ea = model_fwd(pa, live);
    eb = model_fwd(pb, live);
    ec = model_fwd(pc, live);
    check("rf_we",    {127'd0, rf_we},    {127'd0, hist[2].we});
    check("rf_waddr", {121'd0, rf_waddr}, {121'd0, hist[2].addr});
    check("rf_wdata", rf_wdata,           hist[2].data);
    check("retire_count", {112'd0, retire_count}, {112'd0, m_count});
    check("ra_hit", {127'd0, ra_hit}, {127'd0, ea[128]});
    check("ra_fwd", ra_fwd, ea[127:0]);
    check("rb_hit", {127'd0, rb_hit}, {127'd0, eb[128]});
    check("rb_fwd", rb_fwd, eb[127:0]);
    check("rc_hit", {127'd0, rc_hit}, {127'd0, ec[128]});
    check("rc_fwd", rc_fwd, ec[127:0]);
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      m_count = m_count + {15'd0, hist[2].we};
      hist.push_front(live);
      void'(hist.pop_back());
    end
  endtask

  task automatic idle(input int n, input logic [6:0] pa, input logic [6:0] pb, input logic [6:0] pc);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7'd0, 128'd0, pa, pb, pc);
  endtask

  logic [127:0] a5;
  logic [15:0]  prev_cnt;

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1; in_reg_write = 1'b0; flush = 1'b0; in_rt_addr = 7'd0; in_rt = 128'd0;
    ra_addr = 7'd0; rb_addr = 7'd0; rc_addr = 7'd0;
    repeat (2) @(posedge clk);
    model_clear();

    // Reset state, then a single write with 3-cycle latency.
    step(1'b1, 1'b0, 1'b0, 7'd0, 128'd0, 7'd0, 7'd5, 7'd9);
    a5 = {16{8'hA5}};
    step(1'b0, 1'b1, 1'b0, 7'd5, a5, 7'd5, 7'd0, 7'd5);
    idle(5, 7'd5, 7'd0, 7'd6);

    // Priority: three writes to the same address, newest wins.
    step(1'b0, 1'b1, 1'b0, 7'd9, 128'd1, 7'd9, 7'd10, 7'd9);
    step(1'b0, 1'b1, 1'b0, 7'd9, 128'd2, 7'd9, 7'd10, 7'd9);
    step(1'b0, 1'b1, 1'b0, 7'd9, 128'd3, 7'd9, 7'd10, 7'd9);
    idle(4, 7'd9, 7'd10, 7'd9);

    // Flush squashes only the current input.
    step(1'b0, 1'b1, 1'b0, 7'd3, 128'd11, 7'd7, 7'd3, 7'd7);
    step(1'b0, 1'b1, 1'b1, 7'd7, 128'd55, 7'd7, 7'd3, 7'd7);
    idle(4, 7'd7, 7'd3, 7'd0);

    // Reset mid-stream discards in-flight results.
    step(1'b0, 1'b1, 1'b0, 7'd20, rnd128(), 7'd20, 7'd21, 7'd22);
    step(1'b0, 1'b1, 1'b0, 7'd21, rnd128(), 7'd20, 7'd21, 7'd22);
    step(1'b1, 1'b1, 1'b0, 7'd22, rnd128(), 7'd20, 7'd21, 7'd22);
    idle(4, 7'd20, 7'd21, 7'd22);

    // Gaps, including a write to address 0 after idle slots.
    for (int i = 0; i < 8; i++)
      step(1'b0, i[0], 1'b0, i[0] ? 7'd0 : 7'd0, i[0] ? rnd128() : 128'd0, 7'd0, 7'd1, 7'd0);
    idle(4, 7'd0, 7'd1, 7'd0);

    // Random traffic on a narrow address range to exercise collisions.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           7'($urandom_range(0, 7)), rnd128(),
           7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
    end

    // Counter wrap: continuous valid writes past 65535 retirements.
    step(1'b1, 1'b0, 1'b0, 7'd0, 128'd0, 7'd0, 7'd0, 7'd0);
    for (int i = 0; i < 65545; i++) begin
      prev_cnt = m_count;
      step(1'b0, 1'b1, 1'b0, 7'($urandom_range(0, 127)), rnd128(),
           7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      if (prev_cnt == 16'hFFFF) begin
        #1;
        check("retire_wrap", {112'd0, retire_count}, 128'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
